dcache_wb_dm: RTL and testbench
===============================

Name: dcache_wb_dm

Overview:
Direct-mapped, write-back, write-allocate data cache between the pipelined CPU's data-memory port and the slow block-wide main memory.
- CPU side is word-addressed; the cache answers hits in the same cycle.
- On a miss the cache stalls the pipeline and runs a writeback/allocate handshake with memory.
- Block = 4 x 32-bit words (128 bits).

Parameters:
- NUM_BLOCKS, 8, number of cache lines; power of 2, >= 2; IDX_W = log2(NUM_BLOCKS).
- TAG_W, 28-IDX_W, derived tag width (25 at default); not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- proc_read  in  1  CPU load request.
- proc_write  in  1  CPU store request.
- proc_addr  in  30  CPU word address: [1:0] word offset, [IDX_W+1:2] index, [29:IDX_W+2] tag.
- proc_wdata  in  32  store data.
- proc_rdata  out  32  load data.
- proc_stall  out  1  1 = request not complete; CPU holds all proc_* inputs stable.
- mem_read  out  1  block read request.
- mem_write  out  1  block write request.
- mem_addr  out  28  block address {tag,index}.
- mem_wdata  out  128  writeback block; word0 in [31:0].
- mem_rdata  in  128  fill block; word0 in [31:0].
- mem_ready  in  1  one-cycle pulse: current mem transaction complete.

Behaviour:
- Storage per line: valid, dirty, tag[TAG_W], data[128].
  - rst low clears all valid/dirty bits immediately; data and tag contents are don't-care.
- Reset state: state=IDLE. Outputs: proc_stall=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, proc_rdata=0.
- Request handling:
  - req = proc_read | proc_write.
  - If both are high, proc_write has priority; the request is treated as a store.
  - hit = valid[idx] & (tag[idx]==addr tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE. Outputs are decoded combinationally from state and registered line contents.
- IDLE, no req: proc_stall=0; mem_read=0, mem_write=0.
- IDLE, req & hit:
  - proc_stall=0 in the same cycle.
  - Read: proc_rdata = selected word, combinational.
  - Write: the selected word is replaced with proc_wdata and dirty[idx] is set at the clock edge.
- IDLE, req & miss:
  - proc_stall=1 in the same cycle.
  - Next state is WRITEBACK if valid[idx] & dirty[idx], else ALLOCATE.
- WRITEBACK:
  - Drives mem_write=1, mem_addr={stored tag, idx}, mem_wdata=stored line; proc_stall=1.
  - Holds until mem_ready=1, then moves to ALLOCATE. Memory is not rewritten again.
- ALLOCATE:
  - Drives mem_read=1, mem_addr={req tag, idx}; proc_stall=1.
  - On mem_ready=1 the line gets data=mem_rdata, tag=req tag, valid=1, dirty=0; next state is IDLE.
  - The re-examined request then hits. A store merges on that hit cycle and sets dirty.
- Requests are never dropped: the CPU keeps the request asserted through the stall, and completion is the first cycle with proc_stall=0.
- mem_ready is ignored in IDLE. mem_read and mem_write are never high together.
- proc_rdata = 0 whenever it is not (proc_read & ~proc_write & hit & IDLE).
- Miss cost for memory latency L cycles (request to mem_ready):
  - Clean miss: L+1 stall cycles.
  - Dirty miss: 2L+1 stall cycles.
  - Hit: 0.
- Reset mid-transaction: the FSM returns to IDLE and mem_read/mem_write drop immediately. A partially completed allocate leaves no valid line.
- Index wrap: addresses differing only in tag conflict on the same line. The last access wins; a dirty victim is written back first.

Test Plan:
- Reset, then read 0x00000010 with memory returning 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA after L=3 cycles.
  - Required: mem_read=1 with mem_addr=0x0000004, proc_stall high for 4 cycles, then proc_rdata=0xAAAAAAAA.
  - A following read of 0x00000011 returns 0xBBBBBBBB with 0 stall.
- Write 0x12345678 to 0x00000012 (line resident): no stall, no mem traffic. A subsequent read of 0x00000012 returns 0x12345678.
- Conflict after the previous case: read 0x00000032 (same index 4, tag 1).
  - Required: WRITEBACK first, with mem_write=1, mem_addr=0x0000004, mem_wdata=0xDDDDDDDD_12345678_BBBBBBBB_AAAAAAAA.
  - Then ALLOCATE with mem_addr=0x000000C; total stall 7 cycles at L=3.
- Write miss to a clean/invalid line (0x00000100, wdata 0xCAFEF00D).
  - Required: allocate only (no mem_write); after fill the word is updated and dirty set.
  - Evicting it later produces a writeback containing 0xCAFEF00D in word0.
- Assert rst low during ALLOCATE while mem_read=1.
  - Required: mem_read=0 and proc_stall=0 asynchronously; the next read of the same address misses again.
- Pulse mem_ready in IDLE with no request: no state change and no line modified.

Source files
------------

// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU data port
// and a block-wide main memory. Hits complete in the same cycle; misses stall the CPU.
module dcache_wb_dm #(
    parameter int NUM_BLOCKS = 8,
    localparam int IDX_W = $clog2(NUM_BLOCKS),
    localparam int TAG_W = 28 - IDX_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

    state_t state_r;

    logic [NUM_BLOCKS-1:0] valid_r;
    logic [NUM_BLOCKS-1:0] dirty_r;
    logic [TAG_W-1:0]      tag_r  [NUM_BLOCKS];
    logic [127:0]          data_r [NUM_BLOCKS];

    logic             req_s;
    logic             hit_s;
    logic [IDX_W-1:0] idx_s;
    logic [TAG_W-1:0] tag_s;
    logic [1:0]       off_s;
    logic [127:0]     line_s;
    logic [31:0]      word_s;
    logic             store_hit_s;
    logic             fill_s;

    assign req_s       = proc_read | proc_write;
    assign idx_s       = proc_addr[IDX_W+1:2];
    assign tag_s       = proc_addr[29:IDX_W+2];
    assign off_s       = proc_addr[1:0];
    assign line_s      = data_r[idx_s];
    assign word_s      = line_s[{off_s, 5'd0} +: 32];
    assign hit_s       = valid_r[idx_s] & (tag_r[idx_s] == tag_s);
    // A store wins over a simultaneous load.
    assign store_hit_s = (state_r == ST_IDLE) & proc_write & hit_s;
    assign fill_s      = (state_r == ST_ALLOCATE) & mem_ready;

    // Miss handling sequencer: IDLE -> [WRITEBACK] -> ALLOCATE -> IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s && !hit_s) begin
                        if (valid_r[idx_s] && dirty_r[idx_s]) begin
                            state_r <= ST_WRITEBACK;
                        end else begin
                            state_r <= ST_ALLOCATE;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ready) begin
                        state_r <= ST_ALLOCATE;
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Line status bits: cleared by reset, set by fills and store hits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
            dirty_r <= '0;
        end else begin
            if (fill_s) begin
                valid_r[idx_s] <= 1'b1;
                dirty_r[idx_s] <= 1'b0;
            end else if (store_hit_s) begin
                dirty_r[idx_s] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; their contents only matter once valid.
    always_ff @(posedge clk) begin
        if (fill_s) begin
            data_r[idx_s] <= mem_rdata;
            tag_r[idx_s]  <= tag_s;
        end else if (store_hit_s) begin
            data_r[idx_s][{off_s, 5'd0} +: 32] <= proc_wdata;
        end
    end

    // Output decode; everything is forced low while reset is held.
    always_comb begin
        proc_stall = 1'b0;
        proc_rdata = 32'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 28'd0;
        mem_wdata  = 128'd0;
        if (rst) begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s && !hit_s) begin
                        proc_stall = 1'b1;
                    end else begin
                        proc_stall = 1'b0;
                    end
                    if (proc_read && !proc_write && hit_s) begin
                        proc_rdata = word_s;
                    end else begin
                        proc_rdata = 32'd0;
                    end
                end
                ST_WRITEBACK: begin
                    proc_stall = 1'b1;
                    mem_write  = 1'b1;
                    mem_addr   = {tag_r[idx_s], idx_s};
                    mem_wdata  = line_s;
                end
                ST_ALLOCATE: begin
                    proc_stall = 1'b1;
                    mem_read   = 1'b1;
                    mem_addr   = {tag_s, idx_s};
                end
                default: begin
                    proc_stall = 1'b0;
                end
            endcase
        end else begin
            proc_stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache_wb_dm.sv
// Scoreboard bench for dcache_wb_dm: a line-level reference cache plus a latency-
// programmable memory responder; a CPU monitor and the responder check the DUT.
module tb_dcache_wb_dm;
    localparam int NB = 8;
    localparam int IW = 3;
    localparam int TW = 25;

    logic         clk;
    logic         rst;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    dcache_wb_dm #(.NUM_BLOCKS(NB)) dut (
        .clk(clk), .rst(rst),
        .proc_read(proc_read), .proc_write(proc_write), .proc_addr(proc_addr),
        .proc_wdata(proc_wdata), .proc_rdata(proc_rdata), .proc_stall(proc_stall),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] rdata; int stall; } cpu_exp_t;
    typedef struct { logic wr; logic [27:0] addr; logic [127:0] data; } mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int lat = 3;
    int pulse_req = 0;
    int pulse_done = 0;
    logic [127:0] last_wb = 128'd0;

    logic [127:0] resp_mem [logic [27:0]];
    logic [127:0] ref_mem  [logic [27:0]];

    bit           m_valid [NB];
    bit           m_dirty [NB];
    logic [TW-1:0] m_tag  [NB];
    logic [127:0] m_data  [NB];

    function automatic logic [127:0] init_blk(input logic [27:0] a);
        return {4'hA, a, 4'hB, a, 4'hC, a, 4'hD, a};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: apply one CPU access to the line model and queue what must be seen.
    task automatic model_access(input bit rd, input bit wr, input logic [29:0] addr,
                                input logic [31:0] wd);
        int idx;
        int off;
        logic [TW-1:0] tag;
        logic [27:0] blk;
        cpu_exp_t ce;
        mem_exp_t me;
        idx = int'(addr[IW+1:2]);
        off = int'(addr[1:0]);
        tag = addr[29:IW+2];
        blk = addr[29:2];
        ce.stall = 0;
        if (!(m_valid[idx] && m_tag[idx] == tag)) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                me.wr = 1'b1;
                me.addr = {m_tag[idx], 3'(idx)};
                me.data = m_data[idx];
                mem_q.push_back(me);
                ref_mem[me.addr] = m_data[idx];
                ce.stall = 2 * lat + 1;
            end else begin
                ce.stall = lat + 1;
            end
            me.wr = 1'b0;
            me.addr = blk;
            me.data = 128'd0;
            mem_q.push_back(me);
            m_data[idx] = ref_mem.exists(blk) ? ref_mem[blk] : init_blk(blk);
            m_tag[idx] = tag;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            m_data[idx][off*32 +: 32] = wd;
            m_dirty[idx] = 1'b1;
            ce.rdata = 32'd0;
        end else begin
            ce.rdata = m_data[idx][off*32 +: 32];
        end
        if (rd || wr) cpu_q.push_back(ce);
    endtask

    task automatic access(input bit rd, input bit wr, input logic [29:0] addr,
                          input logic [31:0] wd);
        int guard;
        model_access(rd, wr, addr, wd);
        @(posedge clk); #1;
        proc_read = rd; proc_write = wr; proc_addr = addr; proc_wdata = wd;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (proc_stall && guard < 200);
        if (guard >= 200) begin
            $display("FAIL access_timeout: request %h still stalled after %0d cycles", addr, guard);
            $fatal(1, "stall bound expired");
        end
        @(posedge clk); #1;
        proc_read = 1'b0; proc_write = 1'b0;
    endtask

    // CPU monitor: a completion is any cycle with a request and no stall.
    initial begin
        int scnt;
        cpu_exp_t e;
        scnt = 0;
        forever begin
            @(negedge clk);
            chk("mem_rw_exclusive", {1'b0, mem_read & mem_write}, 2'b00);
            if (!rst) begin
                scnt = 0;
            end else if (proc_read || proc_write) begin
                if (proc_stall) begin
                    scnt++;
                end else begin
                    if (cpu_q.size() == 0) begin
                        chk("cpu_unexpected_completion", 1, 0);
                    end else begin
                        e = cpu_q.pop_front();
                        chk("proc_rdata", proc_rdata, e.rdata);
                        chk("stall_cycles", scnt, e.stall);
                    end
                    scnt = 0;
                end
            end else begin
                chk("idle_no_stall", proc_stall, 0);
                scnt = 0;
            end
        end
    end

    // Memory responder: mem_ready lands in the lat-th cycle of each request.
    initial begin
        int cnt;
        mem_exp_t e;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = 128'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cnt = 0;
                mem_ready = 1'b0;
            end else begin
                if (mem_ready) begin
                    mem_ready = 1'b0;
                    cnt = 0;
                end
                if (pulse_req != pulse_done) begin
                    pulse_done++;
                    mem_ready = 1'b1;
                end else if (mem_read || mem_write) begin
                    cnt++;
                    if (cnt >= lat) begin
                        if (mem_q.size() == 0) begin
                            chk("mem_unexpected_request", 1, 0);
                        end else begin
                            e = mem_q.pop_front();
                            chk("mem_is_write", mem_write, e.wr);
                            chk("mem_addr", mem_addr, e.addr);
                            if (mem_write) chk("mem_wdata", mem_wdata, e.data);
                        end
                        if (mem_write) begin
                            resp_mem[mem_addr] = mem_wdata;
                            last_wb = mem_wdata;
                        end else begin
                            mem_rdata = resp_mem.exists(mem_addr) ? resp_mem[mem_addr]
                                                                  : init_blk(mem_addr);
                        end
                        mem_ready = 1'b1;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        logic [29:0] a;
        int sel;
        rst = 1'b0;
        proc_read = 1'b0; proc_write = 1'b0; proc_addr = 30'd0; proc_wdata = 32'd0;
        for (int i = 0; i < NB; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_proc_stall", proc_stall, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_proc_rdata", proc_rdata, 0);
        rst = 1'b1;

        resp_mem[28'h4] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        ref_mem[28'h4]  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        lat = 3;
        access(1'b1, 1'b0, 30'h10, 32'd0);
        access(1'b1, 1'b0, 30'h11, 32'd0);
        access(1'b0, 1'b1, 30'h12, 32'h12345678);
        access(1'b1, 1'b0, 30'h12, 32'd0);
        access(1'b1, 1'b0, 30'h32, 32'd0);
        chk("conflict_writeback_block", last_wb, 128'hDDDDDDDD_12345678_BBBBBBBB_AAAAAAAA);
        access(1'b0, 1'b1, 30'h100, 32'hCAFEF00D);
        access(1'b1, 1'b0, 30'h120, 32'd0);
        chk("evicted_store_word0", last_wb[31:0], 32'hCAFEF00D);

        // mem_ready while idle must not disturb anything
        @(posedge clk); #1;
        pulse_req++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle_pulse_stall", proc_stall, 0);
        chk("idle_pulse_mem_read", mem_read, 0);
        access(1'b1, 1'b0, 30'h120, 32'd0);
        access(1'b1, 1'b0, 30'h11, 32'd0);

        // reset while an allocate is outstanding
        lat = 4;
        @(posedge clk); #1;
        proc_read = 1'b1; proc_addr = 30'h200;
        repeat (2) @(negedge clk);
        chk("abort_mem_read_before", mem_read, 1);
        #2 rst = 1'b0;
        #1;
        chk("abort_mem_read_after", mem_read, 0);
        chk("abort_stall_after", proc_stall, 0);
        proc_read = 1'b0;
        for (int i = 0; i < NB; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        access(1'b1, 1'b0, 30'h200, 32'd0);

        // random traffic over a few tags so lines conflict often
        for (int n = 0; n < 300; n++) begin
            lat = $urandom_range(1, 4);
            a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, NB - 1)), 2'($urandom_range(0, 3))};
            sel = $urandom_range(0, 9);
            if (sel < 5) access(1'b1, 1'b0, a, 32'd0);
            else if (sel < 9) access(1'b0, 1'b1, a, $urandom);
            else access(1'b1, 1'b1, a, $urandom);
            if ($urandom_range(0, 15) == 0) begin
                pulse_req++;
                repeat (2) @(posedge clk);
            end
        end

        repeat (5) @(posedge clk);
        chk("cpu_queue_drained", cpu_q.size(), 0);
        chk("mem_queue_drained", mem_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
